// File: rtl/ccc_lock_clken_gen.sv
// ccc_lock_clken_gen
// Lock-qualified clock-enable generator for a CCC/PLL output on the fabric global clock GL0.
// The asynchronous LOCK input is synchronised and then filtered. Once lock is stable, the
// block releases a downstream reset and produces per-channel divided clock enables.
//
// Optional feature: define CCC_LOCK_LOSS_COUNT_EN to add the 8-bit saturating LOSS_CNT output.
// LOSS_CNT counts RUN->LOST transitions.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_WAIT_LOCK | idle after reset or after a filter abort; waiting for lock_s
// S_FILTER    | counting consecutive lock_s-high cycles toward LOCK_FILT
// S_RUN       | locked: READY/FABRIC_RESET_N high, channel enables running
// S_LOST      | lock dropped while running; outputs held low until relock
module ccc_lock_clken_gen #(
    parameter int N_CH      = 2,
    parameter int DIV_W     = 8,
    parameter int LOCK_FILT = 16
) (
    input  logic                    GL0,
    input  logic                    RESET,
    input  logic                    LOCK,
    input  logic [N_CH*DIV_W-1:0]   DIV,
    input  logic                    DIV_LOAD,
    input  logic                    LOCK_LOST_CLR,
    output logic [N_CH-1:0]         CLKEN,
    output logic                    READY,
    output logic                    FABRIC_RESET_N,
    output logic                    LOCK_LOST
`ifdef CCC_LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0]              LOSS_CNT
`endif
);

    localparam int FILT_W = $clog2(LOCK_FILT + 1);
    // The cycle that moves WAIT_LOCK/LOST into FILTER counts as the first lock_s-high
    // sample. RUN is therefore taken on the edge that sees the LOCK_FILT-th sample.
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_FILTER    = 2'd1,
        S_RUN       = 2'd2,
        S_LOST      = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [FILT_W-1:0] filt_cnt;
    logic [FILT_W-1:0] filt_nxt;

    logic lock_m;
    logic lock_s;

    logic run_now;
    logic run_nxt;
    logic lost_evt;

    logic [DIV_W-1:0] shadow     [N_CH];
    logic [DIV_W-1:0] ch_cnt     [N_CH];
    logic [DIV_W-1:0] ch_cnt_nxt [N_CH];
    logic [N_CH-1:0]  clken_nxt;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge GL0) begin
        if (RESET) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= LOCK;
            lock_s <= lock_m;
        end
    end

    // FSM state and lock-filter counter registers
    always_ff @(posedge GL0) begin
        if (RESET) begin
            state    <= S_WAIT_LOCK;
            filt_cnt <= '0;
        end else begin
            state    <= state_nxt;
            filt_cnt <= filt_nxt;
        end
    end

    // Next-state and filter-count decode
    always_comb begin
        state_nxt = state;
        filt_nxt  = filt_cnt;
        case (state)
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = S_FILTER;
                    filt_nxt  = FILT_W'(1);
                end
            end
            S_FILTER: begin
                if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                    filt_nxt  = '0;
                end else if (filt_cnt >= FILT_LAST) begin
                    state_nxt = S_RUN;
                    filt_nxt  = '0;
                end else begin
                    filt_nxt  = filt_cnt + FILT_W'(1);
                end
            end
            S_RUN: begin
                filt_nxt = '0;
                if (!lock_s) begin
                    state_nxt = S_LOST;
                end
            end
            S_LOST: begin
                if (lock_s) begin
                    state_nxt = S_FILTER;
                    filt_nxt  = FILT_W'(1);
                end
            end
            default: begin
                state_nxt = S_WAIT_LOCK;
                filt_nxt  = '0;
            end
        endcase
    end

    assign run_now  = (state == S_RUN);
    assign run_nxt  = (state_nxt == S_RUN);
    assign lost_evt = run_now && (state_nxt == S_LOST);

    // Per-channel divide counters. Counting happens only while RUN is held across the edge.
    // Leaving RUN clears the counters, and so does a DIV_LOAD. This gives a phase-aligned
    // restart. The enable is computed from the pre-edge count so the pulse is registered.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            ch_cnt_nxt[k] = '0;
            clken_nxt[k]  = 1'b0;
            if (run_now && run_nxt && !DIV_LOAD && (shadow[k] != '0)) begin
                if (ch_cnt[k] == shadow[k] - DIV_W'(1)) begin
                    clken_nxt[k]  = 1'b1;
                    ch_cnt_nxt[k] = '0;
                end else begin
                    ch_cnt_nxt[k] = ch_cnt[k] + DIV_W'(1);
                end
            end
        end
    end

    // Shadow divide ratios, channel counters and registered clock enables
    always_ff @(posedge GL0) begin
        if (RESET) begin
            for (int k = 0; k < N_CH; k++) begin
                shadow[k] <= DIV_W'(1);
                ch_cnt[k] <= '0;
            end
            CLKEN <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (DIV_LOAD) begin
                    shadow[k] <= DIV[k*DIV_W +: DIV_W];
                end
                ch_cnt[k] <= ch_cnt_nxt[k];
            end
            CLKEN <= clken_nxt;
        end
    end

    // READY and the downstream reset are separate flops tracking the RUN state
    always_ff @(posedge GL0) begin
        if (RESET) begin
            READY          <= 1'b0;
            FABRIC_RESET_N <= 1'b0;
        end else begin
            READY          <= run_nxt;
            FABRIC_RESET_N <= run_nxt;
        end
    end

    // Sticky lock-lost flag; a new loss wins over a simultaneous clear
    always_ff @(posedge GL0) begin
        if (RESET) begin
            LOCK_LOST <= 1'b0;
        end else if (lost_evt) begin
            LOCK_LOST <= 1'b1;
        end else if (LOCK_LOST_CLR) begin
            LOCK_LOST <= 1'b0;
        end
    end

`ifdef CCC_LOCK_LOSS_COUNT_EN
    // Saturating count of RUN->LOST events; an increment wins over a simultaneous clear
    always_ff @(posedge GL0) begin
        if (RESET) begin
            LOSS_CNT <= 8'd0;
        end else if (lost_evt) begin
            if (LOSS_CNT != 8'hFF) begin
                LOSS_CNT <= LOSS_CNT + 8'd1;
            end
        end else if (LOCK_LOST_CLR) begin
            LOSS_CNT <= 8'd0;
        end
    end
`endif

endmodule

// File: tb/tb_ccc_lock_clken_gen.sv
// Testbench for ccc_lock_clken_gen (N_CH=2, DIV_W=8, LOCK_FILT=16).
// The outputs are compared every cycle against a behavioural model, and a set of
// hand-computed literal checks pins the model to absolute values.
module tb_ccc_lock_clken_gen;
    localparam int N_CH      = 2;
    localparam int DIV_W     = 8;
    localparam int LOCK_FILT = 16;

    logic                  GL0 = 1'b0;
    logic                  RESET = 1'b1;
    logic                  LOCK = 1'b0;
    logic [N_CH*DIV_W-1:0] DIV = '0;
    logic                  DIV_LOAD = 1'b0;
    logic                  LOCK_LOST_CLR = 1'b0;
    logic [N_CH-1:0]       CLKEN;
    logic                  READY;
    logic                  FABRIC_RESET_N;
    logic                  LOCK_LOST;
`ifdef CCC_LOCK_LOSS_COUNT_EN
    logic [7:0]            LOSS_CNT;
`endif

    int total = 0;
    int bad   = 0;

    ccc_lock_clken_gen #(
        .N_CH      (N_CH),
        .DIV_W     (DIV_W),
        .LOCK_FILT (LOCK_FILT)
    ) dut (
        .GL0            (GL0),
        .RESET          (RESET),
        .LOCK           (LOCK),
        .DIV            (DIV),
        .DIV_LOAD       (DIV_LOAD),
        .LOCK_LOST_CLR  (LOCK_LOST_CLR),
        .CLKEN          (CLKEN),
        .READY          (READY),
        .FABRIC_RESET_N (FABRIC_RESET_N),
        .LOCK_LOST      (LOCK_LOST)
`ifdef CCC_LOCK_LOSS_COUNT_EN
        ,
        .LOSS_CNT       (LOSS_CNT)
`endif
    );

    always #5 GL0 = ~GL0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge GL0);
    endtask

    // ---------------- behavioural model ----------------
    // lock_s is LOCK delayed by two edges. h is the current run length of consecutive
    // lock_s-high samples, and the block is in RUN exactly while h >= LOCK_FILT.
    // age counts edges since the last phase origin (RUN entry or DIV_LOAD).
    // A channel with ratio D fires when age is a positive multiple of D.
    bit            m1, m2;
    int            h;
    bit            m_ready;
    bit [N_CH-1:0] m_clken;
    bit            m_lost;
    int            m_loss;
    int            age;
    int            shadow [N_CH];
    bit            chk_en = 1'b0;

    always @(posedge GL0) begin
        bit rb;
        bit lost_evt;
        rb = m_ready;
        if (RESET) begin
            m1 = 0; m2 = 0; h = 0; m_ready = 0; m_clken = '0;
            m_lost = 0; m_loss = 0; age = 0;
            for (int c = 0; c < N_CH; c++) shadow[c] = 1;
        end else begin
            if (m2) h = (h < LOCK_FILT) ? h + 1 : h;
            else    h = 0;
            m_ready = (h >= LOCK_FILT);
            m2 = m1;
            m1 = LOCK;
            lost_evt = rb && !m_ready;
            if (lost_evt)           m_lost = 1;
            else if (LOCK_LOST_CLR) m_lost = 0;
            if (lost_evt)           m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            else if (LOCK_LOST_CLR) m_loss = 0;
            if (rb && m_ready && !DIV_LOAD) age = age + 1;
            else                            age = 0;
            for (int c = 0; c < N_CH; c++) begin
                m_clken[c] = rb && m_ready && !DIV_LOAD && (shadow[c] != 0) && (age % shadow[c] == 0);
            end
            if (DIV_LOAD) begin
                for (int c = 0; c < N_CH; c++) shadow[c] = int'(DIV[c*DIV_W +: DIV_W]);
            end
        end
        chk_en = 1'b1;
    end

    // Per-cycle compare against the model
    always @(negedge GL0) begin
        if (chk_en) begin
            chk("ready", READY, m_ready);
            chk("fabric_reset_n", FABRIC_RESET_N, m_ready);
            chk("clken", CLKEN, m_clken);
            chk("lock_lost", LOCK_LOST, m_lost);
`ifdef CCC_LOCK_LOSS_COUNT_EN
            chk("loss_cnt", LOSS_CNT, m_loss);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int p0, p1, first0, hi_cnt;

        // Reset state
        cyc(3);
        chk("rst_ready", READY, 0);
        chk("rst_frn", FABRIC_RESET_N, 0);
        chk("rst_clken", CLKEN, 0);
        chk("rst_lock_lost", LOCK_LOST, 0);

        // Reset release with LOCK steady high: RUN on the 18th edge
        RESET = 1'b0;
        LOCK  = 1'b1;
        cyc(17);
        chk("ready_before_filter_done", READY, 0);
        cyc(1);
        chk("ready_after_filter", READY, 1);
        chk("frn_after_filter", FABRIC_RESET_N, 1);
        cyc(1);
        chk("clken_default_div1", CLKEN, 2'b11);

        // ch1=0 (disabled), ch0=4
        DIV = {8'd0, 8'd4};
        DIV_LOAD = 1'b1;
        cyc(1);
        DIV_LOAD = 1'b0;
        chk("clken_on_load_edge", CLKEN, 0);
        p0 = 0; p1 = 0; first0 = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (CLKEN[0] === 1'b1) begin
                p0++;
                if (first0 == 0) first0 = i;
            end
            if (CLKEN[1] === 1'b1) p1++;
        end
        chk("div4_first_pulse", first0, 4);
        chk("div4_pulses_in_20", p0, 5);
        chk("div0_pulses", p1, 0);

        // ch0=1: constant enable after the restart edge
        DIV = {8'd0, 8'd1};
        DIV_LOAD = 1'b1;
        cyc(1);
        DIV_LOAD = 1'b0;
        p0 = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (CLKEN[0] === 1'b1) p0++;
        end
        chk("div1_constant", p0, 10);

        // Lock loss: READY drops three edges after LOCK falls
        LOCK = 1'b0;
        cyc(2);
        chk("ready_2_after_drop", READY, 1);
        cyc(1);
        chk("ready_3_after_drop", READY, 0);
        chk("clken_3_after_drop", CLKEN, 0);
        chk("lock_lost_set", LOCK_LOST, 1);
        LOCK = 1'b1;
        cyc(25);
        chk("ready_relock", READY, 1);
        chk("lock_lost_sticky", LOCK_LOST, 1);
        LOCK_LOST_CLR = 1'b1;
        cyc(1);
        LOCK_LOST_CLR = 1'b0;
        chk("lock_lost_cleared", LOCK_LOST, 0);

        // Loss coincident with clear (set wins) and with DIV_LOAD
        LOCK = 1'b0;
        cyc(2);
        LOCK_LOST_CLR = 1'b1;
        DIV_LOAD = 1'b1;
        DIV = {8'd3, 8'd2};
        cyc(1);
        LOCK_LOST_CLR = 1'b0;
        DIV_LOAD = 1'b0;
        chk("set_wins_over_clr", LOCK_LOST, 1);
        chk("ready_after_loss_load", READY, 0);
        LOCK = 1'b1;
        cyc(18);
        chk("ready_after_loss_load_relock", READY, 1);
        p0 = 0; p1 = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (CLKEN[0] === 1'b1) p0++;
            if (CLKEN[1] === 1'b1) p1++;
        end
        chk("div2_pulses_in_12", p0, 6);
        chk("div3_pulses_in_12", p1, 4);

        // Reset mid-RUN with DIV_LOAD high: reset overrides, shadows back to 1
        DIV = {8'd5, 8'd7};
        DIV_LOAD = 1'b1;
        RESET = 1'b1;
        cyc(1);
        chk("midrun_rst_ready", READY, 0);
        chk("midrun_rst_frn", FABRIC_RESET_N, 0);
        chk("midrun_rst_clken", CLKEN, 0);
        chk("midrun_rst_lock_lost", LOCK_LOST, 0);
        DIV_LOAD = 1'b0;
        RESET = 1'b0;
        cyc(19);
        chk("midrun_rst_ready_again", READY, 1);
        chk("midrun_rst_shadow_is_1", CLKEN, 2'b11);

`ifdef CCC_LOCK_LOSS_COUNT_EN
        for (int n = 0; n < 300; n++) begin
            LOCK = 1'b0;
            cyc(4);
            LOCK = 1'b1;
            cyc(19);
        end
        chk("loss_cnt_saturated", LOSS_CNT, 255);
        LOCK_LOST_CLR = 1'b1;
        cyc(1);
        LOCK_LOST_CLR = 1'b0;
        chk("loss_cnt_cleared", LOSS_CNT, 0);
`endif

        // One-cycle glitch at filter count 10: full re-count, RUN on edge 29
        RESET = 1'b1;
        cyc(2);
        RESET = 1'b0;
        LOCK  = 1'b1;
        cyc(10);
        LOCK = 1'b0;
        cyc(1);
        LOCK = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            cyc(1);
            if (READY !== 1'b0) hi_cnt++;
        end
        chk("glitch_ready_low_during_refilter", hi_cnt, 0);
        cyc(1);
        chk("glitch_ready_after_refilter", READY, 1);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ccc_lock_clken_gen.md
CCC_LOCK_CLKEN_GEN -- requirements
Module: ccc_lock_clken_gen

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of clock-enable channels (1..4).
REQ-002 SHALL have parameter DIV_W, default 8, divide-ratio width per channel (2..16).
REQ-003 SHALL have parameter LOCK_FILT, default 16, consecutive synchronised-LOCK-high cycles required before release (2..1024).
REQ-004 SHALL have port GL0  input  1  fabric global clock, sole clock; all logic on its rising edge.
REQ-005 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port LOCK  input  1  CCC PLL lock, asynchronous to GL0.
REQ-007 SHALL have port DIV  input  N_CH*DIV_W  per-channel divide ratios, channel k at bits [k*DIV_W +: DIV_W].
REQ-008 SHALL have port DIV_LOAD  input  1  one-cycle strobe capturing DIV into shadow registers.
REQ-009 SHALL have port LOCK_LOST_CLR  input  1  clears LOCK_LOST.
REQ-010 SHALL have port CLKEN  output  N_CH  per-channel single-cycle clock enables.
REQ-011 SHALL have port READY  output  1  high in RUN only.
REQ-012 SHALL have port FABRIC_RESET_N  output  1  registered active-low downstream reset, equal to READY.
REQ-013 SHALL have port LOCK_LOST  output  1  sticky flag, lock dropped while in RUN.

Function
REQ-014 SHALL synchronise LOCK through two GL0 flops (lock_s); all decisions use lock_s; LOCK to lock_s latency 2 cycles.
REQ-015 SHALL implement states WAIT_LOCK, FILTER, RUN, LOST.
REQ-016 WAIT_LOCK: lock_s=1 -> FILTER with filter counter=1; else stay.
REQ-017 FILTER: lock_s=1 increments counter; on reaching LOCK_FILT -> RUN next cycle; lock_s=0 clears counter -> WAIT_LOCK.
REQ-018 RUN: lock_s=0 -> LOST next cycle; LOCK_LOST set on same edge.
REQ-019 LOST: lock_s=1 -> FILTER with counter=1; else stay; READY, FABRIC_RESET_N, CLKEN held 0.
REQ-020 Shadow DIV registers SHALL load on DIV_LOAD in any state; all channel counters clear to 0 on the edge after load (phase-aligned restart).
REQ-021 Per channel in RUN: counter counts 0..D-1 and wraps; CLKEN[k]=1 exactly when counter==D-1 (period D cycles, duty 1/D).
REQ-022 D=1 SHALL give CLKEN[k] constant 1 in RUN; D=0 SHALL disable channel (CLKEN[k]=0, counter held 0).
REQ-023 Counters SHALL hold 0 outside RUN; first CLKEN[k] occurs D cycles after entering RUN.
REQ-024 CLKEN SHALL be registered; first pulse D cycles after RUN entry.
REQ-025 LOCK_LOST_CLR SHALL clear LOCK_LOST; simultaneous set and clear: set wins.
REQ-026 DIV_LOAD coincident with RUN->LOST SHALL load shadows; counters remain 0.

Reset
REQ-027 RESET=1 SHALL force state WAIT_LOCK, sync flops 0, filter counter 0, channel counters 0, CLKEN 0, READY 0, FABRIC_RESET_N 0, LOCK_LOST 0.
REQ-028 Reset SHALL load shadow DIV registers with 1 for every channel.
REQ-029 RESET mid-RUN SHALL drop all outputs to reset values on the next edge, overriding all other inputs.

Configuration
REQ-030 Macro CCC_LOCK_LOSS_COUNT_EN defined: SHALL add output LOSS_CNT (8 bits), incremented on every RUN->LOST transition, saturating at 255, cleared by RESET and LOCK_LOST_CLR (increment wins over clear when simultaneous).
REQ-031 Macro undefined: LOSS_CNT port and counter SHALL be absent; all other behaviour identical.

Verification (N_CH=2, DIV_W=8, LOCK_FILT=16)
REQ-032 Reset release, LOCK=1 steady -> READY=1 and FABRIC_RESET_N=1 exactly 2+16 cycles after first LOCK-high edge (±1 for RUN transition edge as REQ-017 defines).
REQ-033 LOCK glitch low 1 cycle at filter count 10 -> WAIT_LOCK, full 16 cycles re-counted, READY stays 0 meanwhile.
REQ-034 RUN, DIV={ch1=0, ch0=4} loaded -> CLKEN[0] pulses every 4 cycles, CLKEN[1] stays 0; then DIV ch0=1 -> CLKEN[0] constant 1.
REQ-035 RUN, LOCK dropped -> 3 cycles later READY=0, CLKEN=0, LOCK_LOST=1; LOCK restored -> RUN after filter; LOCK_LOST stays 1 until LOCK_LOST_CLR.
REQ-036 With CCC_LOCK_LOSS_COUNT_EN: 300 lock-loss events -> LOSS_CNT=255; LOCK_LOST_CLR -> 0.
REQ-037 RESET asserted mid-RUN with DIV_LOAD high -> all outputs 0 next edge, shadows=1.
